// File: rtl/tbl_access_arbiter_if.sv
// rtl/tbl_access_arbiter_if.sv - table access bundle: host port, datapath port, RAM port, busy
//
// Groups every non-clock signal of tbl_access_arbiter.
//   host     : h_rd_req/h_wr_req, h_rd_addr/h_wr_addr, h_wr_data -> h_rd_ack/h_wr_ack, h_rd_data
//   datapath : dp_* with the same widths and meaning as the host port
//   RAM      : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
//   status   : busy
// Modports: slave = arbiter view, master = requesters plus RAM view.
interface tbl_access_arbiter_if #(
    parameter int AW = 2,
    parameter int DW = 128
);
    logic          h_rd_req;
    logic          h_wr_req;
    logic [AW-1:0] h_rd_addr;
    logic [AW-1:0] h_wr_addr;
    logic [DW-1:0] h_wr_data;
    logic          h_rd_ack;
    logic          h_wr_ack;
    logic [DW-1:0] h_rd_data;

    logic          dp_rd_req;
    logic          dp_wr_req;
    logic [AW-1:0] dp_rd_addr;
    logic [AW-1:0] dp_wr_addr;
    logic [DW-1:0] dp_wr_data;
    logic          dp_rd_ack;
    logic          dp_wr_ack;
    logic [DW-1:0] dp_rd_data;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;

    modport slave (
        input  h_rd_req, h_wr_req, h_rd_addr, h_wr_addr, h_wr_data,
        output h_rd_ack, h_wr_ack, h_rd_data,
        input  dp_rd_req, dp_wr_req, dp_rd_addr, dp_wr_addr, dp_wr_data,
        output dp_rd_ack, dp_wr_ack, dp_rd_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output h_rd_req, h_wr_req, h_rd_addr, h_wr_addr, h_wr_data,
        input  h_rd_ack, h_wr_ack, h_rd_data,
        output dp_rd_req, dp_wr_req, dp_rd_addr, dp_wr_addr, dp_wr_data,
        input  dp_rd_ack, dp_wr_ack, dp_rd_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/tbl_access_arbiter.sv
// rtl/tbl_access_arbiter.sv - round-robin host/datapath arbiter for a single-port table RAM
//
// Ports:
//   Bus2IP_Clk     sole clock
//   Bus2IP_Resetn  asynchronous active-low reset
//   tbl            tbl_access_arbiter_if.slave: host and datapath request/ack ports,
//                  RAM strobe/address/data, busy
// One access at a time: grant in IDLE, one RAM cycle in ISSUE, read latency in WAIT_RD,
// one-cycle ack in ACK.
module tbl_access_arbiter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_NUM_COLS       = 4,
    parameter int TBL_NUM_ROWS       = 4,
    parameter int MEM_RD_LATENCY     = 2
) (
    input logic                Bus2IP_Clk,
    input logic                Bus2IP_Resetn,
    tbl_access_arbiter_if.slave tbl
);
    localparam int DW = C_S_AXI_DATA_WIDTH * TBL_NUM_COLS;
    localparam int AW = (TBL_NUM_ROWS > 1) ? $clog2(TBL_NUM_ROWS) : 1;

    // The counter starts one below the latency so the capture lands on the cycle
    // mem_rdata becomes valid (first WAIT_RD cycle when the latency is 1).
    localparam logic [2:0] LAT_INIT = 3'(MEM_RD_LATENCY - 1);

    localparam logic SIDE_HOST = 1'b0;
    localparam logic SIDE_DP   = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;

    logic          last_grant;
    logic          gnt_dp;
    logic          op_wr;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [2:0]    lat_cnt;
    logic [DW-1:0] h_rd_data_q;
    logic [DW-1:0] dp_rd_data_q;

    logic          h_pend;
    logic          dp_pend;
    logic          pick_dp;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          grant;
    logic          capture;
    logic          mem_en_c;
    logic          mem_we_c;
    logic          h_rd_ack_c;
    logic          h_wr_ack_c;
    logic          dp_rd_ack_c;
    logic          dp_wr_ack_c;

    assign h_pend  = tbl.h_rd_req  | tbl.h_wr_req;
    assign dp_pend = tbl.dp_rd_req | tbl.dp_wr_req;

    // Datapath wins when it is the only one asking, or on a tie when the host
    // had the previous grant.
    assign pick_dp = dp_pend & (~h_pend | (last_grant == SIDE_HOST));

    // Within the winning side a write is taken before a read.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (pick_dp) begin
            sel_wr    = tbl.dp_wr_req;
            sel_addr  = tbl.dp_wr_req ? tbl.dp_wr_addr : tbl.dp_rd_addr;
            sel_wdata = tbl.dp_wr_data;
        end else begin
            sel_wr    = tbl.h_wr_req;
            sel_addr  = tbl.h_wr_req ? tbl.h_wr_addr : tbl.h_rd_addr;
            sel_wdata = tbl.h_wr_data;
        end
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        grant       = 1'b0;
        capture     = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        h_rd_ack_c  = 1'b0;
        h_wr_ack_c  = 1'b0;
        dp_rd_ack_c = 1'b0;
        dp_wr_ack_c = 1'b0;
        case (state)
            IDLE: begin
                if (h_pend | dp_pend) begin
                    grant   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                mem_en_c = 1'b1;
                mem_we_c = op_wr;
                state_n  = op_wr ? ACK : WAIT_RD;
            end
            WAIT_RD: begin
                if (lat_cnt == 3'd0) begin
                    capture = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: begin
                h_rd_ack_c  = ~gnt_dp & ~op_wr;
                h_wr_ack_c  = ~gnt_dp &  op_wr;
                dp_rd_ack_c =  gnt_dp & ~op_wr;
                dp_wr_ack_c =  gnt_dp &  op_wr;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            last_grant   <= SIDE_DP;
            gnt_dp       <= 1'b0;
            op_wr        <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_cnt      <= '0;
            h_rd_data_q  <= '0;
            dp_rd_data_q <= '0;
        end else begin
            if (grant) begin
                last_grant <= pick_dp;
                gnt_dp     <= pick_dp;
                op_wr      <= sel_wr;
                lat_addr   <= sel_addr;
                // Reads leave the write-data latch alone so mem_wdata only moves on writes.
                if (sel_wr) begin
                    lat_wdata <= sel_wdata;
                end
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_INIT;
            end else if ((state == WAIT_RD) && (lat_cnt != 3'd0)) begin
                lat_cnt <= lat_cnt - 3'd1;
            end

            if (capture) begin
                if (gnt_dp) begin
                    dp_rd_data_q <= tbl.mem_rdata;
                end else begin
                    h_rd_data_q  <= tbl.mem_rdata;
                end
            end
        end
    end

    assign tbl.mem_en     = mem_en_c;
    assign tbl.mem_we     = mem_we_c;
    assign tbl.mem_addr   = lat_addr;
    assign tbl.mem_wdata  = lat_wdata;
    assign tbl.h_rd_ack   = h_rd_ack_c;
    assign tbl.h_wr_ack   = h_wr_ack_c;
    assign tbl.dp_rd_ack  = dp_rd_ack_c;
    assign tbl.dp_wr_ack  = dp_wr_ack_c;
    assign tbl.h_rd_data  = h_rd_data_q;
    assign tbl.dp_rd_data = dp_rd_data_q;
    assign tbl.busy       = (state != IDLE);

endmodule

// File: tb/tb_tbl_access_arbiter.sv
// tb/tb_tbl_access_arbiter.sv - self-checking bench for tbl_access_arbiter
module tb_tbl_access_arbiter;
    localparam int CW  = 32;
    localparam int NC  = 4;
    localparam int NR  = 4;
    localparam int DW  = CW * NC;
    localparam int AW  = 2;
    localparam int LAT = 2;

    localparam logic [DW-1:0] D0 = 128'h44332211_88776655_CCBBAA99_DDCCBBAA;
    localparam logic [DW-1:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [DW-1:0] D2 = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
    localparam logic [DW-1:0] D3 = 128'hFFFFFFFF_00000000_FFFFFFFF_00000001;
    localparam logic [DW-1:0] D4 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    tbl_access_arbiter_if #(.AW(AW), .DW(DW)) ifc ();

    tbl_access_arbiter #(
        .C_S_AXI_DATA_WIDTH(CW),
        .TBL_NUM_COLS      (NC),
        .TBL_NUM_ROWS      (NR),
        .MEM_RD_LATENCY    (LAT)
    ) u_dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Resetn(rst_n),
        .tbl          (ifc)
    );

    // RAM: write on the strobe edge, read data appears LAT cycles after mem_en;
    // any other cycle shows random junk.
    logic [DW-1:0] ram   [NR];
    logic [DW-1:0] rpipe [8];
    always @(posedge clk) begin
        if (ifc.mem_en && ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
        rpipe[0] <= (ifc.mem_en && !ifc.mem_we) ? ram[ifc.mem_addr]
                                                : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < 8; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ifc.mem_rdata = rpipe[LAT-1];

    int c_h_rd = 0, c_h_wr = 0, c_dp_rd = 0, c_dp_wr = 0;
    always @(posedge clk) begin
        if (ifc.h_rd_ack)  c_h_rd  <= c_h_rd + 1;
        if (ifc.h_wr_ack)  c_h_wr  <= c_h_wr + 1;
        if (ifc.dp_rd_ack) c_dp_rd <= c_dp_rd + 1;
        if (ifc.dp_wr_ack) c_dp_wr <= c_dp_wr + 1;
    end

    // Latency sweep instances: host port only, latencies 1 and 7.
    logic          sw_rd_req [2];
    logic          sw_wr_req [2];
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_wdata;
    logic          sw_rd_ack [2];
    logic          sw_wr_ack [2];
    logic [DW-1:0] sw_rd_data [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_lat
            localparam int L = (g == 0) ? 1 : 7;
            tbl_access_arbiter_if #(.AW(AW), .DW(DW)) ifx ();
            tbl_access_arbiter #(
                .C_S_AXI_DATA_WIDTH(CW),
                .TBL_NUM_COLS      (NC),
                .TBL_NUM_ROWS      (NR),
                .MEM_RD_LATENCY    (L)
            ) u_dut (
                .Bus2IP_Clk   (clk),
                .Bus2IP_Resetn(rst_n),
                .tbl          (ifx)
            );
            logic [DW-1:0] xram  [NR];
            logic [DW-1:0] xpipe [8];
            always @(posedge clk) begin
                if (ifx.mem_en && ifx.mem_we) xram[ifx.mem_addr] <= ifx.mem_wdata;
                xpipe[0] <= (ifx.mem_en && !ifx.mem_we) ? xram[ifx.mem_addr]
                                                        : {$urandom, $urandom, $urandom, $urandom};
                for (int i = 1; i < 8; i++) xpipe[i] <= xpipe[i-1];
            end
            assign ifx.mem_rdata  = xpipe[L-1];
            assign ifx.h_rd_req   = sw_rd_req[g];
            assign ifx.h_wr_req   = sw_wr_req[g];
            assign ifx.h_rd_addr  = sw_addr;
            assign ifx.h_wr_addr  = sw_addr;
            assign ifx.h_wr_data  = sw_wdata;
            assign ifx.dp_rd_req  = 1'b0;
            assign ifx.dp_wr_req  = 1'b0;
            assign ifx.dp_rd_addr = '0;
            assign ifx.dp_wr_addr = '0;
            assign ifx.dp_wr_data = '0;
            assign sw_rd_ack[g]   = ifx.h_rd_ack;
            assign sw_wr_ack[g]   = ifx.h_wr_ack;
            assign sw_rd_data[g]  = ifx.h_rd_data;
        end
    endgenerate

    typedef struct {
        bit            dp;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_of(input int s);
        case (s)
            0:       return ifc.h_rd_ack;
            1:       return ifc.h_wr_ack;
            2:       return ifc.dp_rd_ack;
            default: return ifc.dp_wr_ack;
        endcase
    endfunction

    function automatic int cnt_of(input int s);
        case (s)
            0:       return c_h_rd;
            1:       return c_h_wr;
            2:       return c_dp_rd;
            default: return c_dp_wr;
        endcase
    endfunction

    function automatic logic [6:0] ctl_vec();
        return {ifc.busy, ifc.mem_en, ifc.mem_we,
                ifc.h_rd_ack, ifc.h_wr_ack, ifc.dp_rd_ack, ifc.dp_wr_ack};
    endfunction

    task automatic drop_all();
        ifc.h_rd_req  = 1'b0;
        ifc.h_wr_req  = 1'b0;
        ifc.dp_rd_req = 1'b0;
        ifc.dp_wr_req = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        drop_all();
        for (int i = 0; i < 2; i++) begin
            sw_rd_req[i] = 1'b0;
            sw_wr_req[i] = 1'b0;
        end
        tick();
        tick();
        #4;
        check({nm, " ctl"}, ctl_vec(), 7'b0);
        check({nm, " mem_addr"}, ifc.mem_addr, 0);
        check({nm, " mem_wdata"}, ifc.mem_wdata, 0);
        check({nm, " rd_data"}, {ifc.h_rd_data, ifc.dp_rd_data}, 0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int s, input string nm);
        int k;
        k = 0;
        while (!ack_of(s) && k < 30) begin
            tick();
            #4;
            k++;
        end
        check({nm, " ack seen"}, ack_of(s), 1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int            ack_k;
        int            sel;
        int            own0;
        int            tot0;
        logic [DW-1:0] other_rd;
        sel = (v.dp ? 2 : 0) + (v.wr ? 1 : 0);
        tick();
        own0     = cnt_of(sel);
        tot0     = c_h_rd + c_h_wr + c_dp_rd + c_dp_wr;
        other_rd = v.dp ? ifc.h_rd_data : ifc.dp_rd_data;
        if (v.dp) begin
            if (v.wr) begin
                ifc.dp_wr_req = 1'b1; ifc.dp_wr_addr = v.addr; ifc.dp_wr_data = v.wdata;
            end else begin
                ifc.dp_rd_req = 1'b1; ifc.dp_rd_addr = v.addr;
            end
        end else begin
            if (v.wr) begin
                ifc.h_wr_req = 1'b1; ifc.h_wr_addr = v.addr; ifc.h_wr_data = v.wdata;
            end else begin
                ifc.h_rd_req = 1'b1; ifc.h_rd_addr = v.addr;
            end
        end
        ack_k = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            #4;
            if (k == 1) begin
                check({nm, " mem_en/we"}, {ifc.mem_en, ifc.mem_we}, {1'b1, v.wr});
                check({nm, " mem_addr"}, ifc.mem_addr, v.addr);
                if (v.wr) check({nm, " mem_wdata"}, ifc.mem_wdata, v.wdata);
            end
            if (ack_of(sel)) begin
                ack_k = k;
                break;
            end
        end
        check({nm, " ack latency"}, ack_k, v.exp_lat);
        if (!v.wr) check({nm, " rd_data"}, v.dp ? ifc.dp_rd_data : ifc.h_rd_data, v.exp_rdata);
        tick();
        drop_all();
        #4;
        check({nm, " ack single pulse / idle"}, ctl_vec(), 7'b0);
        check({nm, " other rd_data held"}, v.dp ? ifc.h_rd_data : ifc.dp_rd_data, other_rd);
        check({nm, " ack counts"}, {cnt_of(sel) - own0, c_h_rd + c_h_wr + c_dp_rd + c_dp_wr - tot0},
              {32'd1, 32'd1});
    endtask

    task automatic sweep_txn(input bit is_wr, input string nm, output int a0, output int a1);
        int ack_at [2];
        ack_at[0] = -1;
        ack_at[1] = -1;
        tick();
        for (int i = 0; i < 2; i++) begin
            sw_wr_req[i] = is_wr;
            sw_rd_req[i] = !is_wr;
        end
        for (int k = 0; k < 20 && (ack_at[0] < 0 || ack_at[1] < 0); k++) begin
            if (k > 0) begin
                tick();
                for (int i = 0; i < 2; i++)
                    if (ack_at[i] >= 0) begin
                        sw_wr_req[i] = 1'b0;
                        sw_rd_req[i] = 1'b0;
                    end
            end
            #4;
            for (int i = 0; i < 2; i++) begin
                if (ack_at[i] < 0 && (is_wr ? sw_wr_ack[i] : sw_rd_ack[i])) begin
                    ack_at[i] = k;
                    if (!is_wr) check({nm, " rd_data"}, sw_rd_data[i], sw_wdata);
                end
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            sw_wr_req[i] = 1'b0;
            sw_rd_req[i] = 1'b0;
        end
        #4;
        a0 = ack_at[0];
        a1 = ack_at[1];
    endtask

    // Transaction-level reference: when the arbiter is free and someone is asking,
    // choose the winner by the round-robin rule, then predict strobe and ack cycles.
    task automatic rand_test(input int ncyc);
        bit            rq  [4];
        logic [AW-1:0] ra  [4];
        logic [DW-1:0] wd  [4];
        logic [DW-1:0] ref_mem [NR];
        logic [DW-1:0] h_last, dp_last, e_data;
        logic [AW-1:0] e_addr;
        logic [3:0]    exp_acks;
        bit            e_valid, e_dp, e_wr, lg, hp, dpp, exp_en, exp_busy;
        int            free_at, g_cyc, en_cyc, ack_cyc, s;
        for (int i = 0; i < NR; i++) begin
            vec_t pv;
            pv.dp = 1'b0; pv.wr = 1'b1; pv.addr = AW'(i);
            pv.wdata = {4{32'h5A5A0000 | i}}; pv.exp_lat = 2; pv.exp_rdata = '0;
            ref_mem[i] = pv.wdata;
            run_vec(pv, "preload");
        end
        do_reset("reset before random");
        for (int i = 0; i < 4; i++) begin rq[i] = 1'b0; ra[i] = '0; wd[i] = '0; end
        h_last = '0; dp_last = '0; e_data = '0; e_addr = '0;
        e_valid = 1'b0; e_dp = 1'b0; e_wr = 1'b0; lg = 1'b1;
        free_at = 0; g_cyc = 0; en_cyc = -10; ack_cyc = -10;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (e_valid && ack_cyc == c - 1) begin
                rq[(e_dp ? 2 : 0) + (e_wr ? 1 : 0)] = 1'b0;
                e_valid = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                if (!rq[i] && $urandom_range(3) == 0) begin
                    rq[i] = 1'b1;
                    ra[i] = AW'($urandom_range(NR - 1));
                    wd[i] = {$urandom, $urandom, $urandom, $urandom};
                end
            ifc.h_rd_req  = rq[0]; ifc.h_rd_addr  = ra[0];
            ifc.h_wr_req  = rq[1]; ifc.h_wr_addr  = ra[1]; ifc.h_wr_data  = wd[1];
            ifc.dp_rd_req = rq[2]; ifc.dp_rd_addr = ra[2];
            ifc.dp_wr_req = rq[3]; ifc.dp_wr_addr = ra[3]; ifc.dp_wr_data = wd[3];
            hp  = rq[0] | rq[1];
            dpp = rq[2] | rq[3];
            if (!e_valid && c >= free_at && (hp || dpp)) begin
                if (hp && dpp) e_dp = !lg;
                else           e_dp = dpp;
                e_wr    = rq[(e_dp ? 2 : 0) + 1];
                s       = (e_dp ? 2 : 0) + (e_wr ? 1 : 0);
                e_addr  = ra[s];
                e_data  = e_wr ? wd[s] : ref_mem[ra[s]];
                if (e_wr) ref_mem[e_addr] = wd[s];
                g_cyc   = c;
                en_cyc  = c + 1;
                ack_cyc = e_wr ? c + 2 : c + 2 + LAT;
                free_at = ack_cyc + 1;
                lg      = e_dp;
                e_valid = 1'b1;
            end
            #4;
            exp_en   = e_valid && (c == en_cyc);
            exp_busy = e_valid && (c > g_cyc);
            exp_acks = 4'b0;
            if (e_valid && c == ack_cyc) begin
                exp_acks[3 - ((e_dp ? 2 : 0) + (e_wr ? 1 : 0))] = 1'b1;
                if (!e_wr) begin
                    if (e_dp) dp_last = e_data;
                    else      h_last  = e_data;
                end
            end
            check("rand ctl", ctl_vec(), {exp_busy, exp_en, exp_en & e_wr, exp_acks});
            if (exp_en) begin
                check("rand mem_addr", ifc.mem_addr, e_addr);
                if (e_wr) check("rand mem_wdata", ifc.mem_wdata, e_data);
            end
            check("rand rd_data", {ifc.h_rd_data, ifc.dp_rd_data}, {h_last, dp_last});
        end
        tick();
        drop_all();
    endtask

    initial begin
        int a0, a1, base;
        drop_all();
        ifc.h_rd_addr = '0; ifc.h_wr_addr = '0; ifc.h_wr_data = '0;
        ifc.dp_rd_addr = '0; ifc.dp_wr_addr = '0; ifc.dp_wr_data = '0;
        sw_addr = '0; sw_wdata = '0;

        vecs[0] = '{1'b0, 1'b1, 2'd2, D0, 2, '0};
        vecs[1] = '{1'b0, 1'b0, 2'd2, '0, 4, D0};
        vecs[2] = '{1'b1, 1'b1, 2'd1, D1, 2, '0};
        vecs[3] = '{1'b1, 1'b0, 2'd1, '0, 4, D1};
        vecs[4] = '{1'b0, 1'b0, 2'd1, '0, 4, D1};
        vecs[5] = '{1'b1, 1'b0, 2'd2, '0, 4, D0};
        vecs[6] = '{1'b0, 1'b1, 2'd3, D2, 2, '0};
        vecs[7] = '{1'b1, 1'b0, 2'd3, '0, 4, D2};
        vecs[8] = '{1'b1, 1'b1, 2'd0, D3, 2, '0};
        vecs[9] = '{1'b0, 1'b0, 2'd0, '0, 4, D3};

        do_reset("reset");
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            if (i == 1) check("dp_rd_data untouched by host read", ifc.dp_rd_data, 0);
        end

        // Tie after reset: host first, datapath next, then host again.
        do_reset("reset before tie");
        tick();
        ifc.h_rd_req = 1'b1; ifc.h_rd_addr = 2'd3;
        ifc.dp_rd_req = 1'b1; ifc.dp_rd_addr = 2'd0;
        #4;
        tick(); #4;
        check("tie1 host granted", {ifc.mem_en, ifc.mem_addr}, {1'b1, 2'd3});
        wait_ack(0, "tie1 host");
        check("tie1 host data", ifc.h_rd_data, D2);
        tick(); ifc.h_rd_req = 1'b0; #4;
        tick(); #4;
        check("tie1 dp granted", {ifc.mem_en, ifc.mem_addr}, {1'b1, 2'd0});
        wait_ack(2, "tie1 dp");
        check("tie1 dp data", ifc.dp_rd_data, D3);
        tick();
        ifc.h_rd_req = 1'b1; ifc.h_rd_addr = 2'd1; ifc.dp_rd_addr = 2'd2;
        #4;
        tick(); #4;
        check("tie2 host granted", {ifc.mem_en, ifc.mem_addr}, {1'b1, 2'd1});
        wait_ack(0, "tie2 host");
        check("tie2 host data", ifc.h_rd_data, D1);
        tick(); ifc.h_rd_req = 1'b0; #4;
        tick(); #4;
        check("tie2 dp granted", {ifc.mem_en, ifc.mem_addr}, {1'b1, 2'd2});
        wait_ack(2, "tie2 dp");
        check("tie2 dp data", ifc.dp_rd_data, D0);
        tick(); drop_all(); #4;

        // Write beats read on the same side.
        a0 = c_dp_wr; a1 = c_dp_rd; base = c_h_rd + c_h_wr;
        tick();
        ifc.dp_wr_req = 1'b1; ifc.dp_wr_addr = 2'd1; ifc.dp_wr_data = D4;
        ifc.dp_rd_req = 1'b1; ifc.dp_rd_addr = 2'd1;
        #4;
        tick(); #4;
        check("prio write first", {ifc.mem_en, ifc.mem_we, ifc.mem_wdata}, {1'b1, 1'b1, D4});
        wait_ack(3, "prio wr");
        tick(); ifc.dp_wr_req = 1'b0; #4;
        tick(); #4;
        check("prio read second", {ifc.mem_en, ifc.mem_we}, 2'b10);
        wait_ack(2, "prio rd");
        check("prio rd data", ifc.dp_rd_data, D4);
        tick(); drop_all(); #4;
        check("prio ack counts", {c_dp_wr - a0, c_dp_rd - a1, c_h_rd + c_h_wr - base},
              {32'd1, 32'd1, 32'd0});

        // Reset in WAIT_RD aborts the host read.
        base = c_h_rd;
        tick();
        ifc.h_rd_req = 1'b1; ifc.h_rd_addr = 2'd2;
        #4;
        tick(); #4;
        tick(); #4;
        check("pre-reset busy in WAIT_RD", ifc.busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset ctl", ctl_vec(), 7'b0);
        check("async reset mem/rd_data", {ifc.mem_addr, ifc.h_rd_data, ifc.dp_rd_data}, 0);
        drop_all();
        tick(); tick(); tick(); #4;
        check("no ack after abort", c_h_rd - base, 0);
        tick();
        rst_n = 1'b1;
        run_vec('{1'b0, 1'b0, 2'd2, '0, 4, D0}, "re-request after reset");

        // Latency sweep: 1 and 7.
        sw_addr = 2'd3; sw_wdata = D4 ^ D2;
        sweep_txn(1'b1, "sweep wr", a0, a1);
        check("sweep wr ack L1/L7", {a0, a1}, {32'd2, 32'd2});
        sweep_txn(1'b0, "sweep rd", a0, a1);
        check("sweep rd ack L1", a0, 3);
        check("sweep rd ack L7", a1, 9);

        rand_test(600);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
